// File: rtl/mux8_read_port.sv
// mux8_read_port: burst reader over eight word registers.
// A request captures a start index and a length. Words are then streamed
// out through a registered valid/ready output stage, with the index wrapping
// modulo 8. The last word is flagged, and done pulses once when it is accepted.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req; ptr/cnt captured on req
// READ  | loading words into the output register as it frees up
// LAST  | final word held in out until the consumer takes it
module mux8_read_port #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic             req,
    input  logic [2:0]       addr,
    input  logic [2:0]       len,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    input  logic             ready,
    output logic             last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [2:0]       ptr, ptr_next;
    logic [3:0]       cnt, cnt_next;
    logic [WIDTH-1:0] out_next;
    logic             valid_next, last_next, done_next;
    logic [WIDTH-1:0] d_arr [8];

    // Gather the word registers into an indexable array.
    always_comb begin
        d_arr[0] = d0;
        d_arr[1] = d1;
        d_arr[2] = d2;
        d_arr[3] = d3;
        d_arr[4] = d4;
        d_arr[5] = d5;
        d_arr[6] = d6;
        d_arr[7] = d7;
    end

    assign busy = (state != IDLE);

    // Next-state and next-datapath logic; everything holds unless a rule fires.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        cnt_next   = cnt;
        out_next   = out;
        valid_next = valid;
        last_next  = last;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    ptr_next   = addr;
                    // len of zero means a full sweep of all eight words
                    cnt_next   = (len == 3'd0) ? 4'd8 : {1'b0, len};
                    state_next = READ;
                end
            end
            READ: begin
                // the output register is free if empty or being drained now
                if (!valid || ready) begin
                    out_next   = d_arr[ptr];
                    valid_next = 1'b1;
                    ptr_next   = ptr + 3'd1;
                    cnt_next   = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        last_next  = 1'b1;
                        state_next = LAST;
                    end
                end
            end
            LAST: begin
                if (valid && ready) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            cnt   <= '0;
            out   <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ptr   <= ptr_next;
            cnt   <= cnt_next;
            out   <= out_next;
            valid <= valid_next;
            last  <= last_next;
            done  <= done_next;
        end
    end

endmodule
